// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: WIDTH-bit operands, unsigned or two's-complement,
// full 2*WIDTH-bit product after WIDTH bit steps through a single adder.
module seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   p_q, p_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [PW-1:0]   addend_c;
  logic [PW-1:0]   acc_sum_c;

  // Next-state and datapath; mag_b is consumed LSB first by shifting right each step.
  always_comb begin
    state_d     = state_q;
    mag_a_d     = mag_a_q;
    mag_b_d     = mag_b_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    p_d         = p_q;
    count_d     = count_q;

    addend_c  = mag_b_q[0] ? (PW'(mag_a_q) << count_q) : '0;
    acc_sum_c = acc_q + addend_c;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mag_a_d = (is_signed && a[WIDTH-1]) ? WIDTH'(-a) : a;
          mag_b_d = (is_signed && b[WIDTH-1]) ? WIDTH'(-b) : b;
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          count_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = acc_sum_c;
        mag_b_d = mag_b_q >> 1;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          p_d     = neg_q ? PW'(-acc_sum_c) : acc_sum_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags are registered copies of the state being entered.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      p_q         <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_a_q     <= mag_a_d;
      mag_b_q     <= mag_b_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign p         = p_q;

endmodule
